card_dealer: RTL and testbench

- Card source for the blackjack game. It draws unique cards from a 52-card deck using an LFSR and a dealt-mask, and converts each card to a blackjack value.
- Delivers each card as a one-cycle ready strobe to either the player hand or the master (dealer) hand, using the cardValue/cardReady protocol that both hand accumulators consume.
- Sequences the game: initial deal, player turn, master turn, game over.

---
 rtl/card_pkg.sv | 29 ++
 rtl/card_dealer_if.sv | 25 ++
 rtl/card_dealer_lfsr.sv | 34 +++
 rtl/card_dealer.sv | 140 ++++++++++++++
 tb/tb_card_dealer.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/card_pkg.sv
// rtl/card_pkg.sv - shared phase encoding, deck constants and card value mapping
package card_pkg;

  typedef enum logic [2:0] {
    INIT   = 3'd0,
    PLAYER = 3'd1,
    MASTER = 3'd2,
    DONE   = 3'd3,
    DRAW   = 3'd4
  } phase_t;

  localparam int DECK_SIZE  = 52;
  localparam int RANKS      = 13;
  localparam int ACE_VALUE  = 11;
  localparam int FACE_VALUE = 10;

  // Aces always leave as 11; soft-ace handling lives in the hand accumulators.
  function automatic logic [3:0] rank_to_value(input logic [5:0] index);
    logic [5:0] rank;
    rank = index % 6'(RANKS);
    if (rank == 6'd0)
      rank_to_value = 4'(ACE_VALUE);
    else if (rank >= 6'd10)
      rank_to_value = 4'(FACE_VALUE);
    else
      rank_to_value = 4'(rank + 6'd1);
  endfunction

endpackage

// File: rtl/card_dealer_if.sv
// rtl/card_dealer_if.sv - game request and card delivery signals between dealer and game logic
interface card_dealer_if;
  import card_pkg::*;

  logic       hitPlayer;
  logic       standPlayer;
  logic       finishPlayer;
  logic       finishMaster;
  logic [3:0] cardValue;
  logic       cardReadyPlayer;
  logic       cardReadyMaster;
  logic [5:0] cardsDealt;
  phase_t     phase;
  logic       gameOver;

  modport master (
    input  hitPlayer, standPlayer, finishPlayer, finishMaster,
    output cardValue, cardReadyPlayer, cardReadyMaster, cardsDealt, phase, gameOver
  );

  modport slave (
    output hitPlayer, standPlayer, finishPlayer, finishMaster,
    input  cardValue, cardReadyPlayer, cardReadyMaster, cardsDealt, phase, gameOver
  );
endinterface

// File: rtl/card_dealer_lfsr.sv
// rtl/card_dealer_lfsr.sv - LFSR card picker with dealt mask and draw_req/draw_ack handshake
module card_draw_lfsr
  import card_pkg::*;
#(
  parameter logic [7:0] LFSR_SEED = 8'hA5
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       drawReq,
  output logic       drawAck,
  output logic [5:0] drawIndex
);

  logic [7:0]  lfsr;
  logic [63:0] dealtMask;
  logic        feedback;

  // x^8+x^6+x^5+x^4+1; maximal length, so every 6-bit index shows up within 255 steps.
  assign feedback  = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];
  assign drawIndex = lfsr[5:0];
  assign drawAck   = drawReq && (drawIndex < 6'(DECK_SIZE)) && !dealtMask[drawIndex];

  always_ff @(posedge clock) begin
    if (reset) begin
      lfsr      <= LFSR_SEED;
      dealtMask <= '0;
    end else begin
      lfsr <= {lfsr[6:0], feedback};
      if (drawAck)
        dealtMask[drawIndex] <= 1'b1;
    end
  end

endmodule

// File: rtl/card_dealer.sv
// rtl/card_dealer.sv - blackjack game sequencer and card router; CARD_DEALER_AUTO_STAND_EN adds idle auto-stand
module card_dealer
  import card_pkg::*;
#(
  parameter logic [7:0] LFSR_SEED     = 8'hA5,
  parameter int         STAND_TIMEOUT = 1000
) (
  input  logic          clock,
  input  logic          new_Game,
  card_dealer_if.master bus
);

  typedef enum logic [3:0] {
    S_INIT_P1, S_INIT_M1, S_INIT_P2, S_INIT_M2,
    S_PLAYER_TURN, S_MASTER_TURN,
    S_DRAW, S_DELIVER, S_GAP, S_DONE
  } state_t;

  state_t     state, stateNext;
  state_t     retState, retStateNext;
  logic       toPlayer, toPlayerNext;
  logic       drawReq, drawAck;
  logic [5:0] drawIndex;
  logic [3:0] cardValue;
  logic       readyPlayer, readyMaster;
  logic [5:0] cardsDealt;
  logic       deckEmpty, autoStand, standNow;
  phase_t     phaseNow;

  card_draw_lfsr #(.LFSR_SEED(LFSR_SEED)) drawUnit (
    .clock    (clock),
    .reset    (new_Game),
    .drawReq  (drawReq),
    .drawAck  (drawAck),
    .drawIndex(drawIndex)
  );

  assign deckEmpty = (cardsDealt == 6'(DECK_SIZE));
  assign standNow  = bus.standPlayer || bus.finishPlayer || autoStand;

`ifdef CARD_DEALER_AUTO_STAND_EN
  localparam int CNT_W = $clog2(STAND_TIMEOUT + 1);
  logic [CNT_W-1:0] idleCount;

  always_ff @(posedge clock) begin
    if (new_Game || state != S_PLAYER_TURN || bus.hitPlayer)
      idleCount <= '0;
    else
      idleCount <= idleCount + 1'b1;
  end

  // Fires in the cycle the count reaches the timeout, so the turn ends STAND_TIMEOUT cycles after entry.
  assign autoStand = (state == S_PLAYER_TURN) && !bus.hitPlayer &&
                     (idleCount == CNT_W'(STAND_TIMEOUT - 1));
`else
  assign autoStand = 1'b0;
`endif

  always_comb begin
    stateNext    = state;
    retStateNext = retState;
    toPlayerNext = toPlayer;
    drawReq      = 1'b0;
    unique case (state)
      S_INIT_P1: begin stateNext = S_DRAW; toPlayerNext = 1'b1; retStateNext = S_INIT_M1;     end
      S_INIT_M1: begin stateNext = S_DRAW; toPlayerNext = 1'b0; retStateNext = S_INIT_P2;     end
      S_INIT_P2: begin stateNext = S_DRAW; toPlayerNext = 1'b1; retStateNext = S_INIT_M2;     end
      S_INIT_M2: begin stateNext = S_DRAW; toPlayerNext = 1'b0; retStateNext = S_PLAYER_TURN; end
      S_PLAYER_TURN: begin
        if (standNow) begin
          stateNext = S_MASTER_TURN;
        end else if (bus.hitPlayer && !deckEmpty) begin
          stateNext    = S_DRAW;
          toPlayerNext = 1'b1;
          retStateNext = S_PLAYER_TURN;
        end
      end
      S_MASTER_TURN: begin
        if (bus.finishMaster || deckEmpty) begin
          stateNext = S_DONE;
        end else begin
          stateNext    = S_DRAW;
          toPlayerNext = 1'b0;
          retStateNext = S_MASTER_TURN;
        end
      end
      S_DRAW: begin
        drawReq = 1'b1;
        if (drawAck)
          stateNext = S_DELIVER;
      end
      S_DELIVER: stateNext = S_GAP;
      // Gives the target hand a cycle to update its finish flag before the turn decides again.
      S_GAP:     stateNext = retState;
      S_DONE:    stateNext = S_DONE;
      default:   stateNext = S_INIT_P1;
    endcase
  end

  always_ff @(posedge clock) begin
    if (new_Game) begin
      state       <= S_INIT_P1;
      retState    <= S_INIT_P1;
      toPlayer    <= 1'b0;
      cardValue   <= 4'd0;
      readyPlayer <= 1'b0;
      readyMaster <= 1'b0;
      cardsDealt  <= 6'd0;
    end else begin
      state       <= stateNext;
      retState    <= retStateNext;
      toPlayer    <= toPlayerNext;
      readyPlayer <= drawAck && toPlayer;
      readyMaster <= drawAck && !toPlayer;
      if (drawAck) begin
        cardValue  <= rank_to_value(drawIndex);
        cardsDealt <= cardsDealt + 6'd1;
      end
    end
  end

  always_comb begin
    phaseNow = DRAW;
    case (state)
      S_INIT_P1, S_INIT_M1, S_INIT_P2, S_INIT_M2: phaseNow = INIT;
      S_PLAYER_TURN: phaseNow = PLAYER;
      S_MASTER_TURN: phaseNow = MASTER;
      S_DONE:        phaseNow = DONE;
      default:       phaseNow = DRAW;
    endcase
  end

  assign bus.cardValue       = cardValue;
  assign bus.cardReadyPlayer = readyPlayer;
  assign bus.cardReadyMaster = readyMaster;
  assign bus.cardsDealt      = cardsDealt;
  assign bus.phase           = phaseNow;
  assign bus.gameOver        = (state == S_DONE);

endmodule

// File: tb/tb_card_dealer.sv
// tb/tb_card_dealer.sv - directed self-checking bench for card_dealer
module tb_card_dealer;
  import card_pkg::*;

  logic clock = 1'b0;
  logic new_Game;
  card_dealer_if bus();

  card_dealer dut (
    .clock   (clock),
    .new_Game(new_Game),
    .bus     (bus)
  );

  always #5 clock = ~clock;

  int  tests = 0;
  int  fails = 0;
  byte evTarget[$];
  int  evValue[$];
  int  bothCount = 0;
  int  multiCycle = 0;
  bit  prevP = 1'b0;
  bit  prevM = 1'b0;

  always @(negedge clock) begin
    if (bus.cardReadyPlayer && bus.cardReadyMaster) bothCount++;
    if ((bus.cardReadyPlayer && prevP) || (bus.cardReadyMaster && prevM)) multiCycle++;
    if (bus.cardReadyPlayer) begin
      evTarget.push_back("P");
      evValue.push_back(int'(bus.cardValue));
    end else if (bus.cardReadyMaster) begin
      evTarget.push_back("M");
      evValue.push_back(int'(bus.cardValue));
    end
    prevP = bus.cardReadyPlayer;
    prevM = bus.cardReadyMaster;
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_phase(input phase_t want, input int budget, output bit ok);
    int n;
    n = 0;
    while (bus.phase !== want && n < budget) begin
      tick();
      n++;
    end
    ok = (bus.phase === want);
  endtask

  task automatic restart(input logic masterDone);
    bus.finishMaster = masterDone;
    new_Game = 1'b1;
    tick();
    new_Game = 1'b0;
  endtask

  task automatic test_reset();
    new_Game = 1'b1;
    tick();
    tick();
    tests++; if (bus.cardValue !== 4'd0) begin fails++; $display("FAIL reset_cardValue got=%0d want=0", bus.cardValue); end
    tests++; if (bus.cardReadyPlayer !== 1'b0) begin fails++; $display("FAIL reset_readyPlayer got=%b want=0", bus.cardReadyPlayer); end
    tests++; if (bus.cardReadyMaster !== 1'b0) begin fails++; $display("FAIL reset_readyMaster got=%b want=0", bus.cardReadyMaster); end
    tests++; if (bus.cardsDealt !== 6'd0) begin fails++; $display("FAIL reset_cardsDealt got=%0d want=0", bus.cardsDealt); end
    tests++; if (bus.gameOver !== 1'b0) begin fails++; $display("FAIL reset_gameOver got=%b want=0", bus.gameOver); end
    tests++; if (bus.phase !== INIT) begin fails++; $display("FAIL reset_phase got=%0d want=%0d", bus.phase, INIT); end
    new_Game = 1'b0;
  endtask

  task automatic test_initial_deal(input int base, input string tag);
    bit  ok;
    byte got, exp;
    int  both0, multi0;
    both0  = bothCount;
    multi0 = multiCycle;
    wait_phase(PLAYER, 3000, ok);
    tests++; if (!ok) begin fails++; $display("FAIL %s_timeout phase=%0d want=%0d", tag, bus.phase, PLAYER); end
    tests++; if (evTarget.size() - base !== 4) begin fails++; $display("FAIL %s_count got=%0d want=4", tag, evTarget.size() - base); end
    for (int i = 0; i < 4; i++) begin
      got = (evTarget.size() > base + i) ? evTarget[base + i] : "-";
      exp = (i % 2 == 0) ? "P" : "M";
      tests++; if (got !== exp) begin fails++; $display("FAIL %s_order%0d got=%c want=%c", tag, i, got, exp); end
      if (evValue.size() > base + i) begin
        tests++;
        if (evValue[base + i] < 2 || evValue[base + i] > 11) begin fails++; $display("FAIL %s_value%0d got=%0d want=2..11", tag, i, evValue[base + i]); end
      end
    end
    tests++; if (bus.cardsDealt !== 6'd4) begin fails++; $display("FAIL %s_cardsDealt got=%0d want=4", tag, bus.cardsDealt); end
    tests++; if (multiCycle - multi0 !== 0) begin fails++; $display("FAIL %s_strobe_width got=%0d long strobes want=0", tag, multiCycle - multi0); end
    tests++; if (bothCount - both0 !== 0) begin fails++; $display("FAIL %s_both_strobes got=%0d want=0", tag, bothCount - both0); end
  endtask

  task automatic test_hit_stand();
    int base;
    base = evTarget.size();
    bus.hitPlayer = 1'b1;
    bus.standPlayer = 1'b1;
    tick();
    bus.hitPlayer = 1'b0;
    bus.standPlayer = 1'b0;
    tests++; if (bus.phase !== MASTER) begin fails++; $display("FAIL hit_stand_phase got=%0d want=%0d", bus.phase, MASTER); end
    tick();
    tests++; if (bus.gameOver !== 1'b1) begin fails++; $display("FAIL hit_stand_gameOver got=%b want=1", bus.gameOver); end
    tests++; if (bus.phase !== DONE) begin fails++; $display("FAIL hit_stand_done_phase got=%0d want=%0d", bus.phase, DONE); end
    bus.hitPlayer = 1'b1;
    tick();
    bus.hitPlayer = 1'b0;
    repeat (5) tick();
    tests++; if (evTarget.size() - base !== 0) begin fails++; $display("FAIL hit_stand_strobes got=%0d want=0", evTarget.size() - base); end
    tests++; if (bus.cardsDealt !== 6'd4) begin fails++; $display("FAIL hit_stand_cardsDealt got=%0d want=4", bus.cardsDealt); end
  endtask

  task automatic test_master_draws();
    int n, cycles, base;
    restart(1'b0);
    test_initial_deal(evTarget.size(), "deal2");
    bus.standPlayer = 1'b1;
    tick();
    bus.standPlayer = 1'b0;
    n = 0;
    cycles = 0;
    while (n < 3 && cycles < 3000) begin
      tick();
      cycles++;
      if (bus.cardReadyMaster === 1'b1) n++;
    end
    tests++; if (n !== 3) begin fails++; $display("FAIL master_draw_timeout got=%0d strobes want=3", n); end
    tick();
    bus.finishMaster = 1'b1;
    base = evTarget.size();
    repeat (20) tick();
    tests++; if (evTarget.size() - base !== 0) begin fails++; $display("FAIL master_extra_strobes got=%0d want=0", evTarget.size() - base); end
    tests++; if (bus.gameOver !== 1'b1) begin fails++; $display("FAIL master_gameOver got=%b want=1", bus.gameOver); end
    tests++; if (bus.cardsDealt !== 6'd7) begin fails++; $display("FAIL master_cardsDealt got=%0d want=7", bus.cardsDealt); end
  endtask

  task automatic test_deck_exhaust();
    int base, timeouts, players, sum, tens, aces, twos;
    bit ok;
    restart(1'b1);
    base = evTarget.size();
    test_initial_deal(base, "deal3");
    timeouts = 0;
    for (int h = 0; h < 60; h++) begin
      bus.hitPlayer = 1'b1;
      tick();
      bus.hitPlayer = 1'b0;
      wait_phase(PLAYER, 600, ok);
      if (!ok) timeouts++;
    end
    repeat (5) tick();
    players = 0; sum = 0; tens = 0; aces = 0; twos = 0;
    for (int i = base; i < evTarget.size(); i++) begin
      if (evTarget[i] == "P") players++;
      sum += evValue[i];
      if (evValue[i] == 10) tens++;
      if (evValue[i] == 11) aces++;
      if (evValue[i] == 2) twos++;
    end
    tests++; if (timeouts !== 0) begin fails++; $display("FAIL deck_hit_timeouts got=%0d want=0", timeouts); end
    tests++; if (evTarget.size() - base !== 52) begin fails++; $display("FAIL deck_total_strobes got=%0d want=52", evTarget.size() - base); end
    tests++; if (players !== 50) begin fails++; $display("FAIL deck_player_strobes got=%0d want=50", players); end
    tests++; if (sum !== 380) begin fails++; $display("FAIL deck_value_sum got=%0d want=380", sum); end
    tests++; if (tens !== 16) begin fails++; $display("FAIL deck_tens got=%0d want=16", tens); end
    tests++; if (aces !== 4) begin fails++; $display("FAIL deck_aces got=%0d want=4", aces); end
    tests++; if (twos !== 4) begin fails++; $display("FAIL deck_twos got=%0d want=4", twos); end
    tests++; if (bus.cardsDealt !== 6'd52) begin fails++; $display("FAIL deck_cardsDealt got=%0d want=52", bus.cardsDealt); end
    tests++; if (bus.phase !== PLAYER) begin fails++; $display("FAIL deck_phase got=%0d want=%0d", bus.phase, PLAYER); end
    base = evTarget.size();
    bus.finishMaster = 1'b0;
    bus.standPlayer = 1'b1;
    tick();
    bus.standPlayer = 1'b0;
    repeat (5) tick();
    tests++; if (bus.gameOver !== 1'b1) begin fails++; $display("FAIL deck_empty_master_done got=%b want=1", bus.gameOver); end
    tests++; if (evTarget.size() - base !== 0) begin fails++; $display("FAIL deck_empty_strobes got=%0d want=0", evTarget.size() - base); end
  endtask

  task automatic test_reset_mid_draw();
    restart(1'b0);
    test_initial_deal(evTarget.size(), "deal4");
    bus.standPlayer = 1'b1;
    tick();
    bus.standPlayer = 1'b0;
    tick();
    tests++; if (bus.phase !== DRAW) begin fails++; $display("FAIL middraw_phase got=%0d want=%0d", bus.phase, DRAW); end
    new_Game = 1'b1;
    tick();
    tests++; if (bus.cardReadyPlayer !== 1'b0 || bus.cardReadyMaster !== 1'b0) begin fails++; $display("FAIL middraw_strobes got=%b%b want=00", bus.cardReadyPlayer, bus.cardReadyMaster); end
    tests++; if (bus.cardsDealt !== 6'd0) begin fails++; $display("FAIL middraw_cardsDealt got=%0d want=0", bus.cardsDealt); end
    tests++; if (bus.phase !== INIT) begin fails++; $display("FAIL middraw_restart_phase got=%0d want=%0d", bus.phase, INIT); end
    new_Game = 1'b0;
    test_initial_deal(evTarget.size(), "deal5");
  endtask

  initial begin
    new_Game = 1'b1;
    bus.hitPlayer = 1'b0;
    bus.standPlayer = 1'b0;
    bus.finishPlayer = 1'b0;
    bus.finishMaster = 1'b1;
    test_reset();
    test_initial_deal(evTarget.size(), "deal1");
    test_hit_stand();
    test_master_draws();
    test_deck_exhaust();
    test_reset_mid_draw();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog expired tests=%0d", tests);
    $fatal(1, "watchdog");
  end

endmodule
